// File: rtl/dino_pkg.sv
// Shared constants and types for the dino runner playfield.
// Geometry, obstacle type heights and the LFSR seed live here.
package dino_pkg;

  localparam int SCREEN_W = 160;
  localparam int DINO_X   = 20;
  localparam int DINO_W   = 8;
  localparam int OBS_W    = 4;
  localparam int NSLOT    = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [7:0] SPAWN_X = 8'(SCREEN_W - 1);
  localparam logic [7:0] HIT_LO  = 8'(DINO_X - OBS_W + 1);
  localparam logic [7:0] HIT_HI  = 8'(DINO_X + DINO_W - 1);

  typedef logic [1:0] obs_type_t;

  typedef struct packed {
    logic      valid;
    logic [7:0] x;
    obs_type_t ty;
  } slot_t;

  localparam logic [3:0][7:0] TYPE_H = {8'd10, 8'd8, 8'd6, 8'd4};

  function automatic logic [15:0] type_height(obs_type_t t);
    return {8'd0, TYPE_H[t]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Only the hard reset reseeds it; it runs every clock.
module lfsr16
  import dino_pkg::*;
(
  input  logic        Clock,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  always_ff @(posedge Clock) begin
    if (!reset) q_q <= LFSR_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle playfield: four scrolling slots, spawn pacing,
// and a sticky collision flag against the dino box.
module obstacle_gen
  import dino_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int STEP_DIV        = CLOCK_FREQUENCY / 60,
  parameter int MIN_GAP         = 24
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        reset_game,
  input  logic        ld_game,
  input  logic        ld_pause,
  input  logic        create_obs,
  input  logic [15:0] height,
  output logic        gen,
  output logic        lose,
  output logic        step,
  output logic [3:0]  obsValid,
  output logic [31:0] obsX,
  output logic [7:0]  obsType
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic [TW-1:0] T_LAST = TW'(STEP_DIV - 1);
  localparam logic [GW-1:0] G_MAX  = GW'(MIN_GAP);

  slot_t [NSLOT-1:0] slot_q, slot_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              lose_q, lose_d;
  logic [15:0]       lfsr_q;
  logic              unused_lfsr;

  logic       running;
  logic       step_w;
  logic       any_free;
  logic       gen_w;
  logic       spawn;
  logic       hit;
  logic [1:0] free_idx;

  lfsr16 u_lfsr (
    .Clock (Clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:2];

  always_comb begin
    running  = ld_game & ~ld_pause;
    step_w   = running & (tmr_q == T_LAST);
    any_free = 1'b0;
    free_idx = 2'd0;
    hit      = 1'b0;
    // Descending scan leaves the lowest free index selected.
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        any_free = 1'b1;
        free_idx = 2'(i);
      end
    end
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_q[i].valid &&
          slot_q[i].x >= HIT_LO &&
          slot_q[i].x <= HIT_HI &&
          height < type_height(slot_q[i].ty))
        hit = 1'b1;
    end
    gen_w = running & any_free & (gap_q == G_MAX);
    spawn = create_obs & gen_w;
  end

  always_comb begin
    slot_d = slot_q;
    tmr_d  = tmr_q;
    gap_d  = gap_q;
    lose_d = lose_q | (running & hit);
    if (running) tmr_d = step_w ? '0 : tmr_q + 1'b1;
    if (step_w) begin
      if (gap_q != G_MAX) gap_d = gap_q + 1'b1;
      for (int i = 0; i < NSLOT; i++) begin
        if (slot_q[i].valid) begin
          if (slot_q[i].x == 8'd0) slot_d[i].valid = 1'b0;
          else slot_d[i].x = slot_q[i].x - 8'd1;
        end
      end
    end
    if (spawn) begin
      slot_d[free_idx].valid = 1'b1;
      slot_d[free_idx].x     = SPAWN_X;
      slot_d[free_idx].ty    = lfsr_q[1:0];
      gap_d                  = '0;
    end
    if (reset_game) begin
      slot_d = '0;
      tmr_d  = '0;
      gap_d  = G_MAX;
      lose_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      slot_q <= '0;
      tmr_q  <= '0;
      gap_q  <= G_MAX;
      lose_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      tmr_q  <= tmr_d;
      gap_q  <= gap_d;
      lose_q <= lose_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      obsValid[i]      = slot_q[i].valid;
      obsX[8*i +: 8]   = slot_q[i].x;
      obsType[2*i +: 2] = slot_q[i].ty;
    end
  end

  assign gen  = gen_w;
  assign step = step_w;
  assign lose = lose_q;

endmodule
